led_arbiter: RTL and testbench
==============================

# led_arbiter

Shares the 8-bit blue USER_LED array between up to REQ_N independent pattern sources (heartbeat, status, debug, button echo) on the cyclone 10 gx board. It uses a req/gnt handshake with round-robin fairness, minimum and maximum ownership times, and global PWM brightness dimming. It sits between the pattern generators and the top-level USER_LED pins, clocked by OSC_50m and reset by the synchronized io_master_nreset.

## Interface
- LED_W, 8: LED array width.
- REQ_N, 4: number of requesters, 2..8.
- MIN_HOLD, 50_000_000: minimum grant length in cycles, ≥1.
- MAX_HOLD, 250_000_000: grant length after which a pending competitor forces rotation; MAX_HOLD ≥ MIN_HOLD.
- PWM_W, 4: brightness resolution.
- OSC_50m  in  1  50 MHz clock; sole clock.
- io_master_nreset  in  1  synchronous, active-low reset, sampled on rising OSC_50m.
- req  in  REQ_N  per-requester request level.
- pattern  in  REQ_N*LED_W  requester i drives bits [i*LED_W +: LED_W].
- bright  in  PWM_W  global brightness: 0 = dark, all-ones = always on, otherwise duty bright/2^PWM_W.
- gnt  out  REQ_N  one-hot (or zero) registered grant.
- busy  out  1  registered; high while any grant is held.
- USER_LED  out  LED_W  dimmed, owner-selected pattern.

## Operation
- FSM states (led_pkg enum): IDLE, GRANT, GAP.
- IDLE: gnt=0. If any req is set, choose the winner round-robin, starting from index ptr_q. Set gnt_q to the winner, clear hold_cnt, and go to GRANT. With no req, stay in IDLE.
- GRANT:
  - hold_cnt counts the cycles since the grant, with the first GRANT cycle = 0. It saturates at MAX_HOLD-1.
  - The release condition is evaluated each cycle: hold_cnt ≥ MIN_HOLD-1 AND (req[owner]=0 OR (hold_cnt ≥ MAX_HOLD-1 AND any other req set)).
  - On release: go to GAP, clear gnt_q, set ptr_q = (owner+1) mod REQ_N.
  - Dropping req before MIN_HOLD does not end the grant early.
  - With no competitor, the owner keeps the grant indefinitely after MAX_HOLD.
- GAP: exactly one cycle with gnt=0. Arbitration then proceeds as in IDLE, using req sampled in this cycle (back-to-back handover). If no req is set, go to IDLE.
- led_q:
  - Loads the owner's pattern every GRANT cycle in which req[owner]=1.
  - Otherwise it holds its value, including through GAP, IDLE, and the owner's post-drop MIN_HOLD tail.
  - It clears only on reset.
- PWM:
  - pwm_cnt is a free-running PWM_W-bit counter that wraps.
  - pwm_on_q is registered from (bright == all-ones) OR (pwm_cnt < bright).
  - USER_LED = led_q & {LED_W{pwm_on_q}}.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of FSM state; no grant survives.
- Reset values: state IDLE, gnt 0, busy 0, led_q 0, USER_LED 0, ptr_q 0, hold_cnt 0, pwm_cnt 0, pwm_on_q 0.

## Timing
- req rising at edge t while in IDLE: gnt and busy are high after edge t+1.
- led_q holds the owner pattern after edge t+2. USER_LED shows it in the same cycle if pwm_on_q=1.
- A grant lasts at least MIN_HOLD cycles of gnt high.
- The handover gap between owners is exactly 1 cycle of gnt=0.
- Changes to bright reach USER_LED after 1 cycle, at the next pwm_on_q update.
- All outputs are registered; USER_LED is one AND of two registers.
- The hold_cnt width is $clog2(MAX_HOLD).

## Structure
- Package led_pkg holds:
  - the state enum (IDLE, GRANT, GAP);
  - default LED_W and PWM_W;
  - a localparam for the brightness full-scale value.
- Sub-module rr_arbiter: combinational round-robin pick. Inputs are req[REQ_N] and ptr; outputs are a one-hot grant and an index. It is reusable for future board-resource sharing.
- led_arbiter contains the FSM, hold counter, pattern register and PWM.

## Test plan
Benches use REQ_N=4, MIN_HOLD=4, MAX_HOLD=8, PWM_W=2, bright=3 unless stated.
- Reset: hold io_master_nreset low 3 cycles with random req → gnt=0, busy=0, USER_LED=0x00 throughout. First grant after release goes to the lowest set index.
- Single requester: req[2]=1 with pattern 0xA5 at cycle t → gnt=4'b0100 at t+1, USER_LED=0xA5 at t+2. Drop req after 1 cycle → gnt stays high exactly 4 cycles, then GAP and IDLE, with USER_LED still 0xA5.
- Fairness: req=4'b1111 held constant → grants rotate 0,1,2,3,0. Each grant lasts 8 cycles, separated by 1-cycle gaps.
- Uncontested hold: req[1] only, held 20 cycles → gnt[1] is continuous for all 20 cycles with no rotation.
- Simultaneous handover: owner 0 drops req in the same cycle that req[3] rises, after MIN_HOLD → GAP 1 cycle, then gnt=4'b1000.
- PWM: bright=0 → USER_LED=0 always. bright=1 → 1-of-4 duty. bright=3 → constant pattern. Change bright mid-grant → new duty from the next cycle.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and defaults for the USER_LED arbiter.
package led_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } state_e;

    localparam int unsigned LedWDefault = 8;
    localparam int unsigned PwmWDefault = 4;

    // Brightness code that keeps the LEDs on continuously at the default resolution.
    localparam logic [PwmWDefault-1:0] BrightFullDefault = {PwmWDefault{1'b1}};

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned REQ_N = 4,
    parameter int unsigned IdxW  = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
    input  logic [REQ_N-1:0] req_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [REQ_N-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    int unsigned cand;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < REQ_N; i++) begin
            cand = (32'(ptr_i) + i) % REQ_N;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Shares the USER_LED array between REQ_N pattern sources with round-robin
// req/gnt handover, min/max ownership times and global PWM dimming.
module led_arbiter
    import led_pkg::*;
#(
    parameter int unsigned LED_W    = LedWDefault,
    parameter int unsigned REQ_N    = 4,
    parameter int unsigned MIN_HOLD = 50_000_000,
    parameter int unsigned MAX_HOLD = 250_000_000,
    parameter int unsigned PWM_W    = PwmWDefault
) (
    input  logic                   OSC_50m,
    input  logic                   io_master_nreset,
    input  logic [REQ_N-1:0]       req,
    input  logic [REQ_N*LED_W-1:0] pattern,
    input  logic [PWM_W-1:0]       bright,
    output logic [REQ_N-1:0]       gnt,
    output logic                   busy,
    output logic [LED_W-1:0]       USER_LED
);

    localparam int unsigned IdxW = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CntW-1:0]  MinLast    = CntW'(MIN_HOLD - 1);
    localparam logic [CntW-1:0]  MaxLast    = CntW'(MAX_HOLD - 1);
    localparam logic [PWM_W-1:0] BrightFull = {PWM_W{1'b1}};

    state_e             state_q, state_d;
    logic [REQ_N-1:0]   gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]    hold_q, hold_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [PWM_W-1:0]   pwm_cnt_q;
    logic               pwm_on_q;

    logic [REQ_N-1:0]   arb_gnt;
    logic [IdxW-1:0]    arb_idx;
    logic               arb_valid;
    logic               owner_req;
    logic               others_req;
    logic               release_grant;

    rr_arbiter #(
        .REQ_N (REQ_N),
        .IdxW  (IdxW)
    ) u_rr_arbiter (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Owner keeps the grant until MIN_HOLD has elapsed, then yields on drop
    // or, once MAX_HOLD is reached, to any waiting competitor.
    always_comb begin
        owner_req     = req[owner_q];
        others_req    = |(req & ~gnt_q);
        release_grant = (hold_q >= MinLast) &&
                        (!owner_req || ((hold_q >= MaxLast) && others_req));
    end

    // FSM state register.
    always_ff @(posedge OSC_50m) begin
        if (!io_master_nreset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; GAP arbitrates like IDLE so handover costs one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StGap: state_d = arb_valid ? StGrant : StIdle;
            StGrant:       state_d = release_grant ? StGap : StGrant;
            default:       state_d = StIdle;
        endcase
    end

    // FSM outputs: grant, pointer, hold counter and pattern register next values.
    always_comb begin
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        led_d   = led_q;
        unique case (state_q)
            StIdle, StGap: begin
                gnt_d = '0;
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    owner_d = arb_idx;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                // The post-drop tail keeps showing the last pattern.
                if (owner_req) begin
                    led_d = pattern[32'(owner_q) * LED_W +: LED_W];
                end
                if (release_grant) begin
                    gnt_d = '0;
                    ptr_d = (32'(owner_q) == REQ_N - 1) ? '0 : owner_q + 1'b1;
                end else if (hold_q < MaxLast) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: gnt_d = '0;
        endcase
        busy_d = |gnt_d;
    end

    // Grant, pointer, hold counter and pattern registers.
    always_ff @(posedge OSC_50m) begin
        if (!io_master_nreset) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            led_q   <= '0;
        end else begin
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            led_q   <= led_d;
        end
    end

    // Free-running PWM; full-scale code bypasses the compare so it is truly always on.
    always_ff @(posedge OSC_50m) begin
        if (!io_master_nreset) begin
            pwm_cnt_q <= '0;
            pwm_on_q  <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_on_q  <= (bright == BrightFull) || (pwm_cnt_q < bright);
        end
    end

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign USER_LED = led_q & {LED_W{pwm_on_q}};

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter: per-cycle vector table plus hand sequences
// for rotation, saturation and PWM duty.
module tb_led_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] pattern;
    logic [1:0]  bright;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  user_led;

    int checks;
    int errors;

    led_arbiter #(
        .LED_W    (8),
        .REQ_N    (4),
        .MIN_HOLD (4),
        .MAX_HOLD (8),
        .PWM_W    (2)
    ) dut (
        .OSC_50m          (clk),
        .io_master_nreset (rst_n),
        .req              (req),
        .pattern          (pattern),
        .bright           (bright),
        .gnt              (gnt),
        .busy             (busy),
        .USER_LED         (user_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       busy;
        logic [7:0] led;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int on_cnt;
        int exp_on;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        req     = 4'b0000;
        bright  = 2'd3;
        // req3=3C, req2=A5, req1=5A, req0=0F
        pattern = {8'h3C, 8'hA5, 8'h5A, 8'h0F};

        // Reset held with random requests: nothing may leak out.
        for (int i = 0; i < 3; i++) begin
            req = 4'($urandom_range(0, 15));
            step();
            chk($sformatf("rst%0d gnt", i), 32'(gnt), 32'h0);
            chk($sformatf("rst%0d busy", i), 32'(busy), 32'h0);
            chk($sformatf("rst%0d led", i), 32'(user_led), 32'h0);
        end
        rst_n = 1'b1;
        req   = 4'b0110;
        step();
        chk("first grant lowest", 32'(gnt), 32'h2);
        chk("first grant busy", 32'(busy), 32'h1);

        // Single requester with early drop, then simultaneous handover 0 -> 3.
        vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 8'hA5};
        vecs[4]  = '{1'b1, 4'b0000, 4'b0100, 1'b1, 8'hA5};
        vecs[5]  = '{1'b1, 4'b0000, 4'b0100, 1'b1, 8'hA5};
        vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5};
        vecs[7]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5};
        vecs[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5};
        vecs[9]  = '{1'b1, 4'b0001, 4'b0001, 1'b1, 8'hA5};
        vecs[10] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 8'h0F};
        vecs[11] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 8'h0F};
        vecs[12] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 8'h0F};
        vecs[13] = '{1'b1, 4'b1000, 4'b0000, 1'b0, 8'h0F};
        vecs[14] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 8'h0F};
        vecs[15] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 8'h3C};
        vecs[16] = '{1'b1, 4'b0000, 4'b1000, 1'b1, 8'h3C};
        vecs[17] = '{1'b1, 4'b0000, 4'b1000, 1'b1, 8'h3C};
        vecs[18] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 8'h3C};
        vecs[19] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};

        for (int i = 0; i < 20; i++) begin
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            step();
            chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d led", i), 32'(user_led), 32'(vecs[i].led));
        end

        // Fairness: all requesting, 8-cycle grants rotating 0,1,2,3,0 with 1-cycle gaps.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                chk($sformatf("rot%0d c%0d gnt", k, c), 32'(gnt), 32'(1) << (k % 4));
            end
            if (k < 4) begin
                step();
                chk($sformatf("rot%0d gap gnt", k), 32'(gnt), 32'h0);
                chk($sformatf("rot%0d gap busy", k), 32'(busy), 32'h0);
            end
        end

        // Uncontested owner keeps the grant well past MAX_HOLD.
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("hold c%0d gnt", c), 32'(gnt), 32'h2);
        end

        // PWM duty over 8 cycles at each brightness, owner 1 pattern 5A.
        for (int b = 0; b < 4; b++) begin
            bright = 2'(b);
            step();
            step();
            on_cnt = 0;
            for (int c = 0; c < 8; c++) begin
                step();
                if (user_led == 8'h5A) begin
                    on_cnt++;
                end else begin
                    chk($sformatf("pwm b%0d c%0d dark", b, c), 32'(user_led), 32'h0);
                end
            end
            exp_on = (b == 3) ? 8 : 2 * b;
            chk($sformatf("pwm b%0d on count", b), 32'(on_cnt), 32'(exp_on));
        end

        // Brightness change takes effect after one edge.
        bright = 2'd0;
        step();
        chk("bright to 0", 32'(user_led), 32'h0);
        bright = 2'd3;
        step();
        chk("bright to 3", 32'(user_led), 32'h5A);

        // Saturated owner yields at once to a new competitor.
        req = 4'b1010;
        step();
        chk("sat release gnt", 32'(gnt), 32'h0);
        step();
        chk("sat handover gnt", 32'(gnt), 32'h8);
        chk("sat handover busy", 32'(busy), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
